mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multicycle RISC-V core between two requesters: port 0 (core fetch/load/store) and port 1 (auxiliary master: program loader/debug).
- Grants one transaction at a time using round-robin priority, holds the memory request until the memory acknowledges, and returns completion, read data and a timeout error to the winning requester.
- Sits between the core's address mux output and the memory model.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_WAIT, 16, cycles in BUSY without m_ready before a transaction is aborted (≥1)

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- p0_req  in  1  port 0 request; held with its fields until p0_gnt
- p0_we  in  1  port 0 write enable
- p0_addr  in  AW  port 0 address
- p0_wdata  in  DW  port 0 write data
- p0_wstrb  in  4  port 0 byte strobes
- p0_gnt  out  1  port 0 request accepted (1-cycle pulse)
- p0_rvalid  out  1  port 0 transaction complete (1-cycle pulse, reads and writes)
- p0_rdata  out  DW  port 0 read data, valid with p0_rvalid
- p0_err  out  1  port 0 timeout, valid with p0_rvalid
- p1_req, p1_we, p1_addr, p1_wdata, p1_wstrb, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as port 0, for port 1
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_wstrb  out  4  memory byte strobes
- m_ready  in  1  memory completion; m_rdata valid in the same cycle
- m_rdata  in  DW  memory read data

Behaviour:
- Reset (async, resetn=0): state=IDLE; last_grant=1, so port 0 wins first; wait counter=0. All outputs 0: m_* buses, rdata, err, gnt and rvalid. An in-flight transaction is dropped with no rvalid.
- FSM states: IDLE and BUSY.
- IDLE: if exactly one req is high, that port wins. If both are high, the port ≠ last_grant wins.
  - pX_gnt is combinational and asserted in that same cycle.
  - At the clock edge: latch we/addr/wdata/wstrb and the owner index, set last_grant=owner, set the wait counter to 0, go to BUSY.
  - No req: stay in IDLE, gnt=0.
- BUSY: m_req=1 with the latched fields, stable for the whole state. Both gnt outputs are 0, and requests are held off.
  - When m_ready=1: on the next edge, owner rvalid=1 and rdata=m_rdata (0 for writes), err=0; go to IDLE.
  - Otherwise the counter increments. When counter==MAX_WAIT-1 and m_ready=0: on the next edge, owner rvalid=1, rdata=0, err=1; go to IDLE.
  - m_ready and timeout in the same cycle: m_ready wins, err=0.
- rvalid/err are registered 1-cycle pulses. rdata holds its last value until the next completion.
- The cycle in which rvalid is high is an IDLE cycle, so a new gnt can occur in it.
- Latency:
  - gnt at cycle N; m_req first high at N+1.
  - Earliest m_ready at N+1 gives rvalid at N+2.
  - Back-to-back throughput is one transaction per 2 cycles plus memory wait.
- m_ready while IDLE is ignored.
- A req dropped before gnt is simply not granted; the protocol forbids it and the arbiter does no checking.
- m_req is deasserted in the cycle rvalid rises.

Decomposition:
- Shared package/header mem_arb_pkg: state encodings ST_IDLE/ST_BUSY, port index constants PORT_CORE=0/PORT_AUX=1, default MAX_WAIT.
- One sub-module, rr_arbiter2: 2-input combinational round-robin pick from req[1:0] and last_grant. It outputs a one-hot grant and is reused for any future extra master.
- FSM, latches and timeout counter stay in mem_port_arbiter.

Test Plan:
- Reset, then p0_req read addr=0x100; m_ready asserted 1 cycle after m_req with m_rdata=0xDEADBEEF -> p0_gnt at N, m_req N+1, p0_rvalid at N+2 with p0_rdata=0xDEADBEEF, p0_err=0.
- p0_req and p1_req both held high for 3 transactions, memory 0-wait -> grant order port0, port1, port0; p1_gnt never while BUSY.
- p1 write addr=0x20, wdata=0x12345678, wstrb=0xF; m_ready delayed 5 cycles -> m_* stable all 5 cycles, p1_rvalid once, p1_rdata=0, p1_err=0.
- MAX_WAIT=16, m_ready never asserted -> p0_rvalid=1, p0_err=1, p0_rdata=0 exactly 16 cycles after m_req rises; state returns to IDLE and the next p0_req is granted.
- m_ready rises in the same cycle the counter hits MAX_WAIT-1 -> err=0, rdata=m_rdata.
- resetn pulled low mid-BUSY (async, between edges) -> m_req=0 immediately, no rvalid; after release, p0 wins a simultaneous p0/p1 request.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_e       : FSM encoding (ST_IDLE / ST_BUSY)
//   PORT_CORE/PORT_AUX: requester index values (core = 0, auxiliary master = 1)
//   DEFAULT_MAX_WAIT  : default memory wait budget in BUSY cycles
//   STRB_W            : byte-strobe width of the memory port
//   cnt_width()       : wait-counter width needed for a given wait budget
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

  localparam int DEFAULT_MAX_WAIT = 16;
  localparam int STRB_W           = 4;

  // The counter only has to reach max_wait-1; keep at least one bit so the
  // degenerate max_wait of 1 or 2 still gives a legal vector.
  function automatic int cnt_width(input int max_wait);
    return (max_wait <= 2) ? 1 : $clog2(max_wait);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input combinational round-robin pick.
//   req        : request vector, bit i = requester i
//   last_grant : index of the requester granted most recently
//   gnt        : one-hot grant (all zero when nothing is requesting)
// A lone requester always wins; on a tie the requester that did not win
// last time gets the grant.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // NOTE: every output of a combinational block gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port of the multicycle core between the core
// (port 0) and an auxiliary master (port 1), one transaction at a time.
//   clk, resetn                 : clock, asynchronous active-low reset
//   pX_req/we/addr/wdata/wstrb  : request and its fields, held until pX_gnt
//   pX_gnt                      : combinational accept pulse (IDLE only)
//   pX_rvalid/rdata/err         : registered completion pulse, read data
//                                 (0 for writes/timeouts), timeout flag
//   m_req/we/addr/wdata/wstrb   : memory request, stable for the whole BUSY
//   m_ready, m_rdata            : memory completion with same-cycle data
// A transaction that sees no m_ready for MAX_WAIT BUSY cycles is aborted and
// reported with err=1.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [AW-1:0]     p0_addr,
  input  logic [DW-1:0]     p0_wdata,
  input  logic [STRB_W-1:0] p0_wstrb,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DW-1:0]     p0_rdata,
  output logic              p0_err,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [AW-1:0]     p1_addr,
  input  logic [DW-1:0]     p1_wdata,
  input  logic [STRB_W-1:0] p1_wstrb,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DW-1:0]     p1_rdata,
  output logic              p1_err,

  output logic              m_req,
  output logic              m_we,
  output logic [AW-1:0]     m_addr,
  output logic [DW-1:0]     m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  input  logic              m_ready,
  input  logic [DW-1:0]     m_rdata
);

  localparam int            CW       = cnt_width(MAX_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  arb_state_e        state_q, state_d;
  logic              last_grant_q;
  logic              owner_q;
  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [CW-1:0]     cnt_q;

  logic [1:0]        pick;
  logic              idle;
  logic              busy;
  logic              accept;
  logic              done;
  logic              timeout;
  logic              finish;
  logic [DW-1:0]     result;

  rr_arbiter2 u_rr (
    .req        ({p1_req, p0_req}),
    .last_grant (last_grant_q),
    .gnt        (pick)
  );

  assign idle   = (state_q == ST_IDLE);
  assign busy   = (state_q == ST_BUSY);
  assign accept = idle && (pick != 2'b00);

  // Grants only exist in IDLE, so requests are naturally held off in BUSY.
  assign p0_gnt = idle && pick[0];
  assign p1_gnt = idle && pick[1];

  // m_ready beats the timeout when both land in the same cycle.
  assign done    = busy && m_ready;
  assign timeout = busy && !m_ready && (cnt_q == CNT_LAST);
  assign finish  = done || timeout;
  assign result  = (done && !we_q) ? m_rdata : '0;

  // The memory side is driven straight from the state so it drops the
  // instant the FSM leaves BUSY, including on an asynchronous reset.
  assign m_req   = busy;
  assign m_we    = busy && we_q;
  assign m_addr  = busy ? addr_q  : '0;
  assign m_wdata = busy ? wdata_q : '0;
  assign m_wstrb = busy ? wstrb_q : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (finish) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: the latched transaction fields are plain flops, not a memory, so
  // they are reset along with the control state and never show X.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= PORT_AUX;
      owner_q      <= PORT_CORE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      cnt_q        <= '0;
    end else if (accept) begin
      owner_q      <= pick[1];
      last_grant_q <= pick[1];
      we_q         <= pick[1] ? p1_we    : p0_we;
      addr_q       <= pick[1] ? p1_addr  : p0_addr;
      wdata_q      <= pick[1] ? p1_wdata : p0_wdata;
      wstrb_q      <= pick[1] ? p1_wstrb : p0_wstrb;
      cnt_q        <= '0;
    end else if (busy && !finish) begin
      cnt_q        <= cnt_q + CW'(1);
    end
  end

  // Completion pulses last one cycle; read data holds until that port's
  // next completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p0_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p0_rdata  <= '0;
      p1_rvalid <= 1'b0;
      p1_err    <= 1'b0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p1_rvalid <= 1'b0;
      p1_err    <= 1'b0;
      if (finish) begin
        if (owner_q == PORT_CORE) begin
          p0_rvalid <= 1'b1;
          p0_err    <= timeout;
          p0_rdata  <= result;
        end else begin
          p1_rvalid <= 1'b1;
          p1_err    <= timeout;
          p1_rdata  <= result;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset state, single read latency,
// round-robin under contention, a stalled write, timeout, the ready/timeout
// tie, and an asynchronous reset in the middle of a transaction.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        m_req, m_we, m_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  int checks = 0;
  int errors = 0;
  int lat;

  // Expected grant/completion pattern with both ports requesting and a
  // zero-wait memory, one entry per cycle starting at the first grant.
  logic [5:0] exp_g0  = 6'b010001;  // bit i = cycle i
  logic [5:0] exp_g1  = 6'b000100;
  logic [5:0] exp_rv0 = 6'b000100;
  logic [5:0] exp_rv1 = 6'b010000;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(16)) dut (
    .clk(clk), .resetn(resetn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_wstrb(p0_wstrb), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_wstrb(p1_wstrb), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_wstrb = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_wstrb = 0;
    m_ready = 0; m_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    clear_inputs();
    @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    resetn = 0;
    clear_inputs();
    #12;
    // ---- reset state
    check("rst_m_req",    m_req,     0);
    check("rst_m_addr",   m_addr,    0);
    check("rst_p0_rv",    p0_rvalid, 0);
    check("rst_p1_rdata", p1_rdata,  0);
    check("rst_p0_gnt",   p0_gnt,    0);
    @(negedge clk);
    resetn = 1;

    // ---- single read: gnt N, m_req N+1, rvalid N+2
    @(negedge clk);
    p0_req = 1; p0_we = 0; p0_addr = 32'h100;
    #1;
    check("t1_gnt",    p0_gnt, 1);
    check("t1_mreq_n", m_req,  0);
    @(negedge clk);
    p0_req = 0; m_ready = 1; m_rdata = 32'hDEADBEEF;
    #1;
    check("t1_mreq",  m_req,  1);
    check("t1_maddr", m_addr, 32'h100);
    check("t1_mwe",   m_we,   0);
    check("t1_gnt_b", p0_gnt, 0);
    @(negedge clk);
    m_ready = 0;
    #1;
    check("t1_rvalid", p0_rvalid, 1);
    check("t1_rdata",  p0_rdata,  32'hDEADBEEF);
    check("t1_err",    p0_err,    0);
    check("t1_mreq_d", m_req,     0);
    @(negedge clk);
    #1;
    check("t1_rv_pulse", p0_rvalid, 0);
    check("t1_rd_hold",  p0_rdata,  32'hDEADBEEF);

    // ---- round robin with both ports held high, zero-wait memory
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        p0_req = 1; p1_req = 1; p0_addr = 32'h40; p1_addr = 32'h80;
        m_ready = 1; m_rdata = 32'h11;
      end
      if (i == 5) begin
        p0_req = 0; p1_req = 0;
      end
      #1;
      check($sformatf("rr_g0_%0d", i),  p0_gnt,    exp_g0[i]);
      check($sformatf("rr_g1_%0d", i),  p1_gnt,    exp_g1[i]);
      check($sformatf("rr_rv0_%0d", i), p0_rvalid, exp_rv0[i]);
      check($sformatf("rr_rv1_%0d", i), p1_rvalid, exp_rv1[i]);
    end
    @(negedge clk);
    m_ready = 0;
    #1;
    check("rr_rv0_6", p0_rvalid, 1);
    check("rr_g_6",   {p1_gnt, p0_gnt}, 0);

    // ---- port 1 write with 5 wait cycles
    @(negedge clk);
    p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'h12345678;
    p1_wstrb = 4'hF;
    #1;
    check("t3_gnt", p1_gnt, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) p1_req = 0;
      #1;
      check($sformatf("t3_mreq_%0d", k),  m_req,     1);
      check($sformatf("t3_mwe_%0d", k),   m_we,      1);
      check($sformatf("t3_maddr_%0d", k), m_addr,    32'h20);
      check($sformatf("t3_mwd_%0d", k),   m_wdata,   32'h12345678);
      check($sformatf("t3_mws_%0d", k),   m_wstrb,   4'hF);
      check($sformatf("t3_rv_%0d", k),    p1_rvalid, 0);
    end
    @(negedge clk);
    m_ready = 1; m_rdata = 32'hCAFEF00D;
    #1;
    check("t3_mreq_last", m_req, 1);
    @(negedge clk);
    m_ready = 0;
    #1;
    check("t3_rvalid", p1_rvalid, 1);
    check("t3_rdata",  p1_rdata,  0);
    check("t3_err",    p1_err,    0);
    check("t3_p0rv",   p0_rvalid, 0);
    @(negedge clk);
    #1;
    check("t3_rv_once", p1_rvalid, 0);

    // ---- timeout: rvalid/err 16 cycles after m_req rises
    @(negedge clk);
    p0_req = 1; p0_we = 0; p0_addr = 32'h200;
    #1;
    check("t4_gnt", p0_gnt, 1);
    @(negedge clk);
    p0_req = 0;
    #1;
    check("t4_mreq", m_req, 1);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      #1;
      if (p0_rvalid) break;
    end
    check("t4_latency", lat,      16);
    check("t4_err",     p0_err,   1);
    check("t4_rdata",   p0_rdata, 0);
    check("t4_mreq_d",  m_req,    0);
    // The completion cycle is IDLE, so a new request is granted right away.
    p0_req = 1; p0_addr = 32'h204;
    #1;
    check("t4_regrant", p0_gnt, 1);

    // ---- m_ready on the last allowed cycle beats the timeout
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) p0_req = 0;
      if (k == 16) begin
        m_ready = 1; m_rdata = 32'hA5A55A5A;
      end
      #1;
      check($sformatf("t5_mreq_%0d", k), m_req,     1);
      check($sformatf("t5_rv_%0d", k),   p0_rvalid, 0);
    end
    @(negedge clk);
    m_ready = 0;
    #1;
    check("t5_rvalid", p0_rvalid, 1);
    check("t5_err",    p0_err,    0);
    check("t5_rdata",  p0_rdata,  32'hA5A55A5A);

    // ---- asynchronous reset in the middle of BUSY
    @(negedge clk);
    p0_req = 1; p0_addr = 32'h300;
    #1;
    check("t6_gnt", p0_gnt, 1);
    @(negedge clk);
    p0_req = 0;
    #1;
    check("t6_mreq", m_req, 1);
    #2;
    resetn = 0;
    #1;
    check("t6_mreq_rst",  m_req,    0);
    check("t6_maddr_rst", m_addr,   0);
    check("t6_rdata_rst", p0_rdata, 0);
    @(negedge clk);
    #1;
    check("t6_no_rv_a", p0_rvalid, 0);
    @(negedge clk);
    #1;
    check("t6_no_rv_b", p0_rvalid, 0);
    @(negedge clk);
    resetn = 1;
    p0_req = 1; p1_req = 1;
    #1;
    check("t6_g0", p0_gnt, 1);
    check("t6_g1", p1_gnt, 0);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
